// File: rtl/fetch_stage_pkg.sv
// Shared types for the rv32i fetch stage.
//   rv32i_types : register index and major opcode encodings
//   instr_types : decoded instruction record carried in IF/ID
//   fetch_types : fetch controller state encoding

package rv32i_types;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OPCODE_W = 7;

  typedef logic [REG_W-1:0] rv32i_reg;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } opcode_t;
endpackage

package instr_types;
  import rv32i_types::*;

  typedef struct packed {
    opcode_t         opcode;
    rv32i_reg        rd;
    logic [2:0]      funct3;
    rv32i_reg        rs1;
    rv32i_reg        rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] s_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] u_imm;
    logic [XLEN-1:0] j_imm;
  } instr_t;
endpackage

package fetch_types;
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_stage_decode.sv
// instr_decode: splits a raw RV32I word into register fields and
// sign-extended immediates. Purely combinational.
//   i_word  : 32-bit instruction word
//   o_instr : decoded fields (instr_types::instr_t)

module instr_decode
  import rv32i_types::*;
  import instr_types::*;
(
  input  logic [XLEN-1:0] i_word,
  output instr_t          o_instr
);

  always_comb begin
    o_instr        = '0;
    o_instr.opcode = opcode_t'(i_word[6:0]);
    o_instr.rd     = i_word[11:7];
    o_instr.funct3 = i_word[14:12];
    o_instr.rs1    = i_word[19:15];
    o_instr.rs2    = i_word[24:20];
    o_instr.funct7 = i_word[31:25];
    o_instr.i_imm  = {{21{i_word[31]}}, i_word[30:20]};
    o_instr.s_imm  = {{21{i_word[31]}}, i_word[30:25], i_word[11:7]};
    o_instr.b_imm  = {{20{i_word[31]}}, i_word[7], i_word[30:25], i_word[11:8], 1'b0};
    o_instr.u_imm  = {i_word[31:12], 12'h000};
    o_instr.j_imm  = {{12{i_word[31]}}, i_word[19:12], i_word[20], i_word[30:21], 1'b0};
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues held-request reads to the I-cache,
// decodes returned words and writes the IF/ID pipeline register.
// Handles downstream stall (one-entry skid) and EX redirect, including a
// redirect that lands while a cache request is still outstanding.
//   clk, rst                 : clock, async active-high reset
//   icache_read/address      : held read request to the I-cache
//   icache_rdata/resp        : one-cycle response strobe and word
//   stall_i                  : IF/ID must hold
//   redirect_i/redirect_pc_i : taken branch/jump from EX, flushes IF/ID
//   if_id_*                  : IF/ID pipeline register contents

module fetch_stage
  import rv32i_types::*;
  import instr_types::*;
  import fetch_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
)
(
  input  logic            clk,
  input  logic            rst,
  output logic            icache_read,
  output logic [XLEN-1:0] icache_address,
  input  logic [XLEN-1:0] icache_rdata,
  input  logic            icache_resp,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_ir,
  output instr_t          if_id_instr
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_read;
  logic [XLEN-1:0] r_addr;     // in KILL this holds the abandoned (kill) address
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_ir;
  logic            r_if_id_valid;
  logic [XLEN-1:0] r_if_id_pc;
  logic [XLEN-1:0] r_if_id_ir;
  instr_t          r_if_id_instr;

  logic            w_resp;
  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_dec_word;
  instr_t          w_dec;

  // A response only counts while a request is actually outstanding.
  assign w_resp        = icache_resp & r_read;
  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
  assign w_pc_next     = r_pc + PC_STEP;

  // Single decoder on the IF/ID load path: skid word when draining HOLD.
  assign w_dec_word = (r_state == HOLD) ? r_skid_ir : icache_rdata;

  instr_decode u_decode (
    .i_word  (w_dec_word),
    .o_instr (w_dec)
  );

  // Fetch controller, PC and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_read        <= 1'b0;
      r_addr        <= RESET_PC;
      r_skid_pc     <= '0;
      r_skid_ir     <= '0;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_ir    <= '0;
      r_if_id_instr <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect_i) begin
            r_if_id_valid <= 1'b0;
            r_pc          <= w_redirect_pc;
            if (w_resp || !r_read) begin
              // Nothing left in flight: start the new stream next cycle.
              r_read <= 1'b1;
              r_addr <= w_redirect_pc;
            end else begin
              // Request must stay held until the cache answers; drop its word.
              r_state <= KILL;
            end
          end else if (w_resp) begin
            r_pc   <= w_pc_next;
            r_addr <= w_pc_next;
            if (stall_i) begin
              r_skid_pc <= r_pc;
              r_skid_ir <= icache_rdata;
              r_read    <= 1'b0;
              r_state   <= HOLD;
            end else begin
              r_read        <= 1'b1;
              r_if_id_valid <= 1'b1;
              r_if_id_pc    <= r_pc;
              r_if_id_ir    <= icache_rdata;
              r_if_id_instr <= w_dec;
            end
          end else begin
            if (!stall_i) begin
              r_if_id_valid <= 1'b0;
            end
            r_read <= 1'b1;
            r_addr <= r_pc;
          end
        end

        HOLD: begin
          if (redirect_i) begin
            r_if_id_valid <= 1'b0;
            r_pc          <= w_redirect_pc;
            r_addr        <= w_redirect_pc;
            r_read        <= 1'b1;
            r_state       <= FETCH;
          end else if (!stall_i) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_skid_pc;
            r_if_id_ir    <= r_skid_ir;
            r_if_id_instr <= w_dec;
            r_read        <= 1'b1;
            r_addr        <= r_pc;
            r_state       <= FETCH;
          end
        end

        KILL: begin
          if (redirect_i) begin
            r_if_id_valid <= 1'b0;
            r_pc          <= w_redirect_pc;
          end
          if (w_resp) begin
            r_addr  <= redirect_i ? w_redirect_pc : r_pc;
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  assign icache_read    = r_read;
  assign icache_address = r_addr;
  assign if_id_valid    = r_if_id_valid;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_ir       = r_if_id_ir;
  assign if_id_instr    = r_if_id_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID entries go into a queue as
// stimulus is issued; a monitor pops and compares each entry consumed by the
// downstream stage (valid & !stall).

module tb_fetch_stage;
  import rv32i_types::*;
  import instr_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_ir;
  instr_t      if_id_instr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b1;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_read    (icache_read),
    .icache_address (icache_address),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_ir       (if_id_ir),
    .if_id_instr    (if_id_instr)
  );

  // Instruction memory image seen by the cache model.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0060: mem = 32'hFE01_0113; // addi x2,x2,-32
      32'h0000_0064: mem = 32'hFFDF_F0EF; // jal  x1,-4
      32'h0000_0068: mem = 32'hFE21_AC23; // sw   x2,-8(x3)
      32'h0000_0200: mem = 32'hFE00_08E3; // beq  x0,x0,-16
      32'h0000_0204: mem = 32'h1234_52B7; // lui  x5,0x12345
      default:       mem = a ^ 32'hC0DE_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.ir = mem(pc);
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus, applied at the falling edge.
  task automatic step(input logic rsp, input logic stl, input logic rdr, input logic [31:0] rpc);
    @(negedge clk);
    icache_resp   = rsp;
    icache_rdata  = rsp ? mem(icache_address) : 32'hDEAD_BEEF;
    stall_i       = stl;
    redirect_i    = rdr;
    redirect_pc_i = rpc;
  endtask

  // Monitor: compare each consumed IF/ID entry against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !rst && if_id_valid && !stall_i) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ifid: got pc %08h ir %08h expected nothing", if_id_pc, if_id_ir);
        end else begin
          e = exp_q.pop_front();
          check("if_id_pc", if_id_pc, e.pc);
          check("if_id_ir", if_id_ir, e.ir);
          case (e.ir)
            32'hFE01_0113: begin
              check("addi_opcode", 32'(if_id_instr.opcode), 32'h13);
              check("addi_rd",     32'(if_id_instr.rd),     32'd2);
              check("addi_rs1",    32'(if_id_instr.rs1),    32'd2);
              check("addi_funct3", 32'(if_id_instr.funct3), 32'd0);
              check("addi_i_imm",  if_id_instr.i_imm,       32'hFFFF_FFE0);
            end
            32'hFFDF_F0EF: begin
              check("jal_opcode", 32'(if_id_instr.opcode), 32'h6F);
              check("jal_rd",     32'(if_id_instr.rd),     32'd1);
              check("jal_j_imm",  if_id_instr.j_imm,       32'hFFFF_FFFC);
            end
            32'hFE21_AC23: begin
              check("sw_opcode", 32'(if_id_instr.opcode), 32'h23);
              check("sw_rs1",    32'(if_id_instr.rs1),    32'd3);
              check("sw_rs2",    32'(if_id_instr.rs2),    32'd2);
              check("sw_funct3", 32'(if_id_instr.funct3), 32'd2);
              check("sw_s_imm",  if_id_instr.s_imm,       32'hFFFF_FFF8);
            end
            32'hFE00_08E3: begin
              check("beq_opcode", 32'(if_id_instr.opcode), 32'h63);
              check("beq_b_imm",  if_id_instr.b_imm,       32'hFFFF_FFF0);
            end
            32'h1234_52B7: begin
              check("lui_opcode", 32'(if_id_instr.opcode), 32'h37);
              check("lui_rd",     32'(if_id_instr.rd),     32'd5);
              check("lui_u_imm",  if_id_instr.u_imm,       32'h1234_5000);
            end
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got %0d queued expected 0", exp_q.size());
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    icache_resp   = 1'b0;
    icache_rdata  = '0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;

    // Reset: no request, IF/ID empty.
    repeat (3) begin
      @(negedge clk);
      check("rst_read",  32'(icache_read), 32'd0);
      check("rst_valid", 32'(if_id_valid), 32'd0);
    end
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_if_id_ir", if_id_ir, 32'h0);
    rst = 1'b0;

    // Back-to-back responses: one instruction per cycle.
    push(32'h60); push(32'h64); push(32'h68); push(32'h6C);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("first_read", 32'(icache_read), 32'd1);
    check("first_addr", icache_address, 32'h60);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("b2b_addr1", icache_address, 32'h64);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("b2b_addr3", icache_address, 32'h6C);

    // Redirect to 0x200 while 0x70 is still outstanding.
    step(1'b0, 1'b0, 1'b1, 32'h200);
    check("pend_addr0", icache_address, 32'h70);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("kill_addr", icache_address, 32'h70);
    check("kill_read", 32'(icache_read), 32'd1);
    check("kill_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("kill_resp_addr", icache_address, 32'h70);
    check("kill_resp_valid", 32'(if_id_valid), 32'd0);

    // New stream at 0x200, then stall while 0x204 returns.
    push(32'h200); push(32'h204);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_addr", icache_address, 32'h200);
    check("redir_valid", 32'(if_id_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_addr", icache_address, 32'h204);
    repeat (2) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("hold_read", 32'(icache_read), 32'd0);
      check("hold_if_id_pc", if_id_pc, 32'h200);
      check("hold_valid", 32'(if_id_valid), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("release_if_id_pc", if_id_pc, 32'h200);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("skid_if_id_pc", if_id_pc, 32'h204);
    check("skid_valid", 32'(if_id_valid), 32'd1);
    check("skid_read", 32'(icache_read), 32'd1);
    check("skid_next_addr", icache_address, 32'h208);

    // Redirect coincident with response and stall: flush, no HOLD.
    step(1'b1, 1'b1, 1'b1, 32'h103);
    check("bubble_valid", 32'(if_id_valid), 32'd0);
    push(32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("flush_addr", icache_address, 32'h100);
    check("flush_read", 32'(icache_read), 32'd1);
    check("flush_valid", 32'(if_id_valid), 32'd0);

    // Redirect to the top word (low bits cleared), then PC wrap.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check("pre_wrap_if_id_pc", if_id_pc, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("kill2_addr", icache_address, 32'h104);
    push(32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("top_addr", icache_address, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap_addr", icache_address, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("drain_valid", 32'(if_id_valid), 32'd0);

    @(negedge clk);
    #2;
    mon_en = 1'b0;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
